// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, one stop bit.
// Each bit lasts Prescale CLK cycles. Prescale is 6 bits wide so that the 32x rate can be represented.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            cyc_q, cyc_d;
    logic [4:0]            last_cyc_q, last_cyc_d;
    logic [IDX_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [4:0]            presc_last;
    logic                  bit_done;

    // Unsupported rates (including 0) fall back to 8 so a bit is never zero cycles long.
    always_comb begin
        case (Prescale)
            6'd16:   presc_last = 5'd15;
            6'd32:   presc_last = 5'd31;
            default: presc_last = 5'd7;
        endcase
    end

    assign bit_done = (cyc_q == last_cyc_q);

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        last_cyc_d = last_cyc_q;
        bit_d      = bit_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (Data_Valid) begin
                    state_d    = S_START;
                    data_d     = P_DATA;
                    par_en_d   = PAR_EN;
                    par_bit_d  = PAR_TYP ? ~(^P_DATA) : (^P_DATA);
                    last_cyc_d = presc_last;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    cyc_d   = '0;
                    bit_d   = '0;
                end else begin
                    cyc_d = cyc_q + 5'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cyc_d = '0;
                    if (bit_q == LAST_IDX) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 5'd1;
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 5'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so TX_OUT comes straight off a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[bit_d];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            last_cyc_q <= 5'd7;
            bit_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            last_cyc_q <= last_cyc_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
